pp_operand_sequencer: RTL and testbench

Operand-side counterpart of the partial-product accumulator in the execution unit. It latches two 16x16 operand pairs (16-bit mode) or one 32x32 operand pair (32-bit mode) and drives byte slices into the two 8x8 unsigned multipliers, one partial product per cycle. The issue order and timing run in lockstep with the accumulator's PP states. The multipliers are combinational, so the accumulator consumes in cycle N the operands issued in cycle N.

---
 rtl/pp_operand_sequencer_if.sv | 25 ++
 rtl/pp_operand_sequencer.sv | 96 +++++++++
 tb/tb_pp_operand_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pp_operand_sequencer_if.sv
// Operand-sequencer bus: start/operand request in, multiplier byte slices and status out.
interface pp_operand_sequencer_if;
   logic        start;
   logic        mode_32bit;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [7:0]  mul1_a;
   logic [7:0]  mul1_b;
   logic [7:0]  mul2_a;
   logic [7:0]  mul2_b;
   logic        pp_valid;
   logic [3:0]  pp_index;
   logic        ready;
   logic        seq_done;

   modport master (
      output start, mode_32bit, op_a, op_b,
      input  mul1_a, mul1_b, mul2_a, mul2_b, pp_valid, pp_index, ready, seq_done
   );

   modport slave (
      input  start, mode_32bit, op_a, op_b,
      output mul1_a, mul1_b, mul2_a, mul2_b, pp_valid, pp_index, ready, seq_done
   );
endinterface

// File: rtl/pp_operand_sequencer.sv
// Latches one 32x32 or two 16x16 operand pairs and issues byte slices to the two
// 8x8 multipliers, one partial product per cycle, in lockstep with the accumulator.
module pp_operand_sequencer (
   input  logic                   clk,
   input  logic                   rst,
   pp_operand_sequencer_if.slave  bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        mode_q, mode_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  last_idx;
   logic        issue;

   assign last_idx = mode_q ? 4'd15 : 4'd3;
   assign issue    = (state_q == S_ISSUE);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               mode_d  = bus.mode_32bit;
               cnt_d   = 4'd0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // start is ignored here: a dropped start never aborts the sequence
            if (cnt_q == last_idx) begin
               cnt_d   = 4'd0;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_HOLD: begin
            if (!bus.start) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         mode_q  <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   // Multipliers are combinational, so slices are driven straight from the latches
   always_comb begin
      bus.mul1_a   = 8'd0;
      bus.mul1_b   = 8'd0;
      bus.mul2_a   = 8'd0;
      bus.mul2_b   = 8'd0;
      bus.pp_valid = issue;
      bus.pp_index = issue ? cnt_q : 4'd0;
      bus.ready    = (state_q == S_IDLE);
      bus.seq_done = (state_q == S_HOLD);
      if (issue) begin
         if (mode_q) begin
            bus.mul1_a = a_q[{cnt_q[1:0], 3'b000} +: 8];
            bus.mul1_b = b_q[{cnt_q[3:2], 3'b000} +: 8];
         end else begin
            bus.mul1_a = cnt_q[1] ? a_q[15:8]  : a_q[7:0];
            bus.mul1_b = cnt_q[0] ? b_q[15:8]  : b_q[7:0];
            bus.mul2_a = cnt_q[1] ? a_q[31:24] : a_q[23:16];
            bus.mul2_b = cnt_q[0] ? b_q[31:24] : b_q[23:16];
         end
      end
   end
endmodule

// File: tb/tb_pp_operand_sequencer.sv
// Directed-vector bench for pp_operand_sequencer with hand-computed byte slices.
module tb_pp_operand_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   pp_operand_sequencer_if bus ();

   pp_operand_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] obs_bytes;
   assign obs_bytes = {bus.mul1_a, bus.mul1_b, bus.mul2_a, bus.mul2_b};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_valid"}, {31'd0, bus.pp_valid}, 32'd0);
      chk({tag, "_bytes"}, obs_bytes, 32'd0);
   endtask

   task automatic chk_issue(input string tag, input int k, input logic [31:0] exp_bytes);
      chk({tag, "_vld_idx"}, {27'd0, bus.pp_valid, bus.pp_index}, {27'd0, 1'b1, 4'(k)});
      chk({tag, "_bytes"}, obs_bytes, exp_bytes);
   endtask

   task automatic run16(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] ex [4];
      ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      bus.op_a = a; bus.op_b = b; bus.mode_32bit = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_issue("m16", k, ex[k]);
         tick();
      end
      chk("m16_done", {31'd0, bus.seq_done}, 32'd1);
      chk_quiet("m16_hold");
      tick();
      chk("m16_done_drop", {30'd0, bus.seq_done, bus.ready}, 32'd1);
   endtask

   // Expected 32-bit mode slice for the fixed operands 04030201 / 08070605
   function automatic logic [31:0] exp32(input int k);
      return {8'(k % 4 + 1), 8'(k / 4 + 5), 16'h0000};
   endfunction

   task automatic run32(input int freeze_at, input int rst_at);
      bus.op_a = 32'h04030201; bus.op_b = 32'h08070605;
      bus.mode_32bit = 1'b1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k == rst_at) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
            chk("m32_rst_ready", {31'd0, bus.ready}, 32'd1);
            chk("m32_rst_done", {31'd0, bus.seq_done}, 32'd0);
            chk_quiet("m32_rst");
            return;
         end
         chk_issue("m32", k, exp32(k));
         if (k == freeze_at) begin
            bus.op_a = 32'hFFFFFFFF;
            bus.mode_32bit = 1'b0;
         end
         tick();
      end
      chk("m32_done", {31'd0, bus.seq_done}, 32'd1);
      chk_quiet("m32_hold");
      tick();
      chk("m32_ready", {31'd0, bus.ready}, 32'd1);
   endtask

   initial begin
      int issues;
      bus.start = 1'b1; bus.mode_32bit = 1'b1;
      bus.op_a = 32'hDEADBEEF; bus.op_b = 32'hCAFEF00D;
      rst = 1'b0;
      repeat (3) tick();
      chk("rst_ready", {31'd0, bus.ready}, 32'd1);
      chk("rst_done", {31'd0, bus.seq_done}, 32'd0);
      chk("rst_idx", {28'd0, bus.pp_index}, 32'd0);
      chk_quiet("rst");
      bus.start = 1'b0;
      rst = 1'b1;
      tick();

      run16(32'h00FF1234, 32'h00025678, 32'h3478FF02, 32'h3456FF00, 32'h12780002, 32'h12560000);
      run16(32'hBEEFCAFE, 32'h13579BDF, 32'hFEDFEF57, 32'hFE9BEF13, 32'hCADFBE57, 32'hCA9BBE13);

      run32(-1, -1);
      run32(2, -1);

      // start held for 30 cycles: one sequence only, seq_done held until release
      bus.op_a = 32'h00FF1234; bus.op_b = 32'h00025678;
      bus.mode_32bit = 1'b0; bus.start = 1'b1;
      tick();
      issues = 0;
      for (int c = 1; c < 30; c++) begin
         if (bus.pp_valid) issues++;
         chk("hold_valid", {31'd0, bus.pp_valid}, {31'd0, c <= 4});
         chk("hold_done", {31'd0, bus.seq_done}, {31'd0, c >= 5});
         tick();
      end
      bus.start = 1'b0;
      chk("hold_release_done", {31'd0, bus.seq_done}, 32'd1);
      tick();
      chk("hold_issues", 32'(issues), 32'd4);
      chk("hold_back_idle", {30'd0, bus.seq_done, bus.ready}, 32'd1);
      chk_quiet("hold_idle");

      run32(-1, 7);
      run16(32'h00FF1234, 32'h00025678, 32'h3478FF02, 32'h3456FF00, 32'h12780002, 32'h12560000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
